imm_extend_unit: RTL and testbench



---
 rtl/imm_extend_unit.sv | 119 +++++++++++
 tb/tb_imm_extend_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/imm_extend_unit.sv
// Registered immediate extender: sign, zero, sign+shift and two-beat concat modes, one-cycle latency.
// Define IMM_EXT_CONCAT_EN to build the concat mode and its HELD state; otherwise mode 3 acts as mode 0.
module imm_extend_unit #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    logic [OUT_W-1:0] sext_w;
    logic [OUT_W-1:0] zext_w;
    logic [OUT_W-1:0] shft_w;

    // Sized signed casts avoid zero-width replications at the OUT_W boundary.
    assign sext_w = OUT_W'($signed(in_data));
    assign zext_w = OUT_W'(in_data);
    assign shft_w = sext_w << SHIFT;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;

`ifdef IMM_EXT_CONCAT_EN
    // state   | meaning
    // ST_IDLE | no high beat held, busy=0
    // ST_HELD | high beat stored in held_q, waiting for the low beat, busy=1
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    state_t           state_q;
    logic [IN_W-1:0]  held_q;
    logic             busy_q;
    logic [2*IN_W-1:0] pair_w;
    logic [OUT_W-1:0] cat_w;

    assign pair_w = {held_q, in_data};
    assign cat_w  = OUT_W'($signed(pair_w));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
                case (mode)
                    2'd0: begin
                        out_data_q  <= sext_w;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                    2'd1: begin
                        out_data_q  <= zext_w;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                    2'd2: begin
                        out_data_q  <= shft_w;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                    default: begin
                        if (state_q == ST_HELD) begin
                            out_data_q  <= cat_w;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            held_q  <= in_data;
                            state_q <= ST_HELD;
                            busy_q  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
                out_valid_q <= 1'b1;
                case (mode)
                    2'd1:    out_data_q <= zext_w;
                    2'd2:    out_data_q <= shft_w;
                    default: out_data_q <= sext_w;
                endcase
            end
        end
    end

    assign busy = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit (IN_W=8, OUT_W=16, SHIFT=1); follows IMM_EXT_CONCAT_EN if defined.
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  mode = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    imm_extend_unit #(.IN_W(8), .OUT_W(16), .SHIFT(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .mode     (mode),
        .out_valid(out_valid),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Apply a beat on the falling edge, then step just past the next rising edge.
    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        mode     = m;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [15:0] d, input logic b);
        checks++;
        if (out_valid !== v || out_data !== d || busy !== b) begin
            failures++;
            $display("FAIL %s: got valid=%0b data=%h busy=%0b, want valid=%0b data=%h busy=%0b",
                     name, out_valid, out_data, busy, v, d, b);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        expect_out("reset_state", 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_out("after_reset_idle", 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_sign_zero;
        drive(1'b1, 2'd0, 8'h83); expect_out("sext_83", 1'b1, 16'hFF83, 1'b0);
        drive(1'b1, 2'd1, 8'h83); expect_out("zext_83", 1'b1, 16'h0083, 1'b0);
        drive(1'b1, 2'd0, 8'h7F); expect_out("sext_7f", 1'b1, 16'h007F, 1'b0);
        drive(1'b0, 2'd0, 8'hFF); expect_out("idle_hold", 1'b0, 16'h007F, 1'b0);
    endtask

    task automatic test_shift;
        drive(1'b1, 2'd2, 8'h83); expect_out("shift_83", 1'b1, 16'hFF06, 1'b0);
        drive(1'b1, 2'd2, 8'h7F); expect_out("shift_7f", 1'b1, 16'h00FE, 1'b0);
        drive(1'b1, 2'd2, 8'h00); expect_out("shift_00", 1'b1, 16'h0000, 1'b0);
    endtask

`ifdef IMM_EXT_CONCAT_EN
    task automatic test_concat;
        drive(1'b1, 2'd3, 8'h12); expect_out("cat_hi_12", 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 2'd3, 8'h34); expect_out("cat_1234", 1'b1, 16'h1234, 1'b0);
        drive(1'b1, 2'd3, 8'h80); expect_out("cat_hi_80", 1'b0, 16'h1234, 1'b1);
        drive(1'b1, 2'd3, 8'h01); expect_out("cat_8001", 1'b1, 16'h8001, 1'b0);
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 2'd3, 8'hAB); expect_out("b2b_hi", 1'b0, 16'h8001, 1'b1);
        drive(1'b1, 2'd3, 8'hCD); expect_out("b2b_abcd", 1'b1, 16'hABCD, 1'b0);
        drive(1'b1, 2'd3, 8'hEF); expect_out("b2b_next_hi", 1'b0, 16'hABCD, 1'b1);
        drive(1'b1, 2'd3, 8'h01); expect_out("b2b_ef01", 1'b1, 16'hEF01, 1'b0);
    endtask

    task automatic test_abort;
        drive(1'b1, 2'd3, 8'h12); expect_out("abort_hi", 1'b0, 16'hEF01, 1'b1);
        drive(1'b1, 2'd0, 8'h03); expect_out("abort_0003", 1'b1, 16'h0003, 1'b0);
        drive(1'b0, 2'd3, 8'h00); expect_out("abort_idle", 1'b0, 16'h0003, 1'b0);
        drive(1'b1, 2'd3, 8'h44); expect_out("abort_new_hi", 1'b0, 16'h0003, 1'b1);
        drive(1'b1, 2'd3, 8'h66); expect_out("abort_4466", 1'b1, 16'h4466, 1'b0);
    endtask

    task automatic test_gaps;
        drive(1'b1, 2'd3, 8'h56); expect_out("gap_hi", 1'b0, 16'h4466, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd3, 8'hFF); expect_out("gap_hold", 1'b0, 16'h4466, 1'b1);
        end
        drive(1'b1, 2'd3, 8'h78); expect_out("gap_5678", 1'b1, 16'h5678, 1'b0);
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 2'd3, 8'h55); expect_out("rst_hi_55", 1'b0, 16'h5678, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 expect_out("rst_async_clear", 1'b0, 16'h0000, 1'b0);
        #1 reset = 1'b0;
        drive(1'b1, 2'd3, 8'hAA); expect_out("rst_hi_aa", 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 2'd3, 8'hBB); expect_out("rst_aabb", 1'b1, 16'hAABB, 1'b0);
    endtask
`else
    task automatic test_mode3_as_sign;
        drive(1'b1, 2'd3, 8'h83); expect_out("m3_sext_83", 1'b1, 16'hFF83, 1'b0);
        drive(1'b1, 2'd3, 8'h12); expect_out("m3_sext_12", 1'b1, 16'h0012, 1'b0);
        drive(1'b0, 2'd3, 8'hAA); expect_out("m3_idle", 1'b0, 16'h0012, 1'b0);
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 2'd1, 8'hC5); expect_out("rst_pre", 1'b1, 16'h00C5, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 expect_out("rst_async_clear", 1'b0, 16'h0000, 1'b0);
        #1 reset = 1'b0;
        drive(1'b1, 2'd3, 8'hAA); expect_out("rst_after_aa", 1'b1, 16'hFFAA, 1'b0);
    endtask
`endif

    initial begin
        test_reset;
        test_sign_zero;
        test_shift;
`ifdef IMM_EXT_CONCAT_EN
        test_concat;
        test_back_to_back;
        test_abort;
        test_gaps;
        test_reset_mid;
`else
        test_mode3_as_sign;
        test_reset_mid;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
